alu_operand_fetch: RTL and testbench
====================================

Name: alu_operand_fetch

Overview:
Decode/operand-fetch stage directly upstream of the floating-point/logic ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Reads two operands from a 32x32 register file and drives the ALU's OpCode, x1 and x2 inputs.
- Tracks in-flight destinations with a scoreboard so an instruction never issues on stale data.
- Result writeback from downstream updates the register file and clears the scoreboard.

Parameters:
NREGS, 32, number of architectural registers; register index width is clog2(NREGS)=5.
DW, 32, data width (IEEE-754 single precision or raw bits).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept an instruction this cycle
in_inst  in  32  [31:29] op, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] ignored
OpCode  out  3  ALU opcode (registered)
x1  out  32  operand A (registered)
x2  out  32  operand B (registered)
out_valid  out  1  one-cycle pulse: OpCode/x1/x2/out_rd hold a new issued op
out_rd  out  5  destination tag travelling with the op
wb_valid  in  1  writeback strobe
wb_rd  in  5  writeback register
wb_data  in  32  writeback value
illegal_op  out  1  one-cycle pulse when an illegal opcode is dropped

Behaviour:
- Reset (async assert, sync deassert by the user): all outputs 0, rf[*]=0, pending[*]=0, decode register empty, in_ready=1 after reset.
- Legal ops: 000 add, 001 sub, 011 mul, 100 and, 101 or, 110 xor. Opcodes 010 and 111 are illegal.
- Decode register D: holds one instruction.
  - in_ready = !D.valid || issue.
  - Handshake completes when in_valid && in_ready. The instruction is loaded into D on that edge.
- Hazard (evaluated on D each cycle): pending[rs1] || pending[rs2] || pending[rd]. This covers RAW and WAW. Register 0 is never pending.
- Writeback bypass: a same-cycle writeback to a hazarded register is treated as not pending.
  - Operand read uses wb_data when wb_rd matches rs and wb_valid is high (rs != 0).
- issue = D.valid && legal && !hazard.
  - On the issue edge: OpCode, x1, x2 and out_rd are registered, out_valid=1 for exactly one cycle, pending[rd] set (unless rd=0).
  - OpCode/x1/x2 hold their last values while out_valid=0.
- Illegal op in D: dropped on the next edge regardless of hazard, illegal_op=1 for one cycle, no issue, no scoreboard change.
- Latency: acceptance edge N -> out_valid high after edge N+1 when no hazard. Throughput is 1 per cycle; the ALU has no backpressure.
- Writeback:
  - rf[wb_rd] <= wb_data and pending[wb_rd] cleared on the edge, unless wb_rd=0.
  - A writeback to a non-pending register is legal; it is used for preloading.
- Register 0 reads as 0x00000000 always; writes to it are ignored.
- Simultaneous issue setting pending[r] and writeback clearing pending[r]: the set wins.
- Reset mid-stall: D is emptied, the scoreboard is cleared, and the held instruction is lost.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110)
  - instruction field bit positions
  - legal-opcode function
- One natural sub-module: alu_regfile. It is 32x32 with two asynchronous read ports with write bypass, one synchronous write port, and r0 hardwired to zero.
- Scoreboard and handshake logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, x1=x2=0, OpCode=0, illegal_op=0, in_ready=1 immediately after release.
- Preload and add:
  - Stimulus: wb r1=0x4048F5C3, r2=0xC048F5C3, then inst 0x03088000 (add r3,r1,r2).
  - Response: out_valid one cycle after D loads, OpCode=000, x1=0x4048F5C3, x2=0xC048F5C3, out_rd=3.
- RAW stall:
  - Stimulus: next inst 0x64184000 (mul r4,r3,r1) while r3 pending.
  - Response: no issue and in_ready=0 while stalled. In the cycle of wb r3=0x00000000, the next edge issues OpCode=011, x1=0x00000000 (bypass), x2=0x4048F5C3.
- Illegal op: inst 0xE5000000 -> illegal_op pulse, no out_valid, pending[5] stays 0.
- r0 rule: wb r0=0x7F800000, then inst 0xA6000000 (or r6,r0,r0) -> x1=x2=0x00000000, OpCode=101, no stall.
- Reset mid-stall: hold mul r4,r3,r1 stalled, pulse rst_n low -> pending cleared, D empty, in_ready=1, no out_valid ever appears for that instruction.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and helpers for the ALU operand-fetch stage
//
// Provides register-file geometry, ALU opcode encodings, instruction field
// bit positions and the legal-opcode check used by the decode stage.
package alu_pkg;

    localparam int NREGS = 32;
    localparam int DW    = 32;
    localparam int RW    = $clog2(NREGS);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    // Least-significant bit of each instruction field; bits [13:0] carry nothing.
    localparam int OP_LSB  = 29;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 19;
    localparam int RS2_LSB = 14;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_operand_fetch_if.sv
// rtl/alu_operand_fetch_if.sv - instruction, ALU issue and writeback signal bundle
//
// master: instruction source / writeback producer / ALU side (drives in_*, wb_*)
// slave : the operand-fetch stage (drives in_ready, OpCode, x1, x2, out_*, illegal_op)
interface alu_operand_fetch_if;
    import alu_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [2:0]    OpCode;
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
    logic          out_valid;
    logic [RW-1:0] out_rd;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          illegal_op;

    modport master (
        output in_valid, in_inst, wb_valid, wb_rd, wb_data,
        input  in_ready, OpCode, x1, x2, out_valid, out_rd, illegal_op
    );

    modport slave (
        input  in_valid, in_inst, wb_valid, wb_rd, wb_data,
        output in_ready, OpCode, x1, x2, out_valid, out_rd, illegal_op
    );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 32x32 register file, two async read ports with write bypass
//
// Ports: clk, rst_n (async active-low, clears all entries), we/waddr/wdata
// (synchronous write), raddr1/rdata1 and raddr2/rdata2 (combinational reads).
// Register 0 always reads zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [RW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] rf [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            rf[waddr] <= wdata;
        end
    end

    // A same-cycle write is forwarded so a stalled reader can issue on the
    // writeback edge itself instead of one cycle later.
    always_comb begin
        rdata1 = rf[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = rf[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/alu_operand_fetch.sv
// rtl/alu_operand_fetch.sv - decode / operand-fetch stage feeding the ALU
//
// Ports: clk, rst_n (async active-low), bus (slave side of alu_operand_fetch_if):
//   in_valid/in_ready/in_inst  instruction handshake
//   OpCode/x1/x2/out_rd        registered issue, qualified by the out_valid pulse
//   wb_valid/wb_rd/wb_data     downstream result writeback
//   illegal_op                 pulse when an illegal instruction is discarded
module alu_operand_fetch
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_fetch_if.slave bus
);

    logic          d_valid;
    logic [2:0]    d_op;
    logic [RW-1:0] d_rd;
    logic [RW-1:0] d_rs1;
    logic [RW-1:0] d_rs2;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] eff_pending;
    logic [NREGS-1:0] set_mask;

    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          hazard;
    logic          issue;
    logic          drop;
    logic          accept;
    logic          unused_inst_lo;

    assign unused_inst_lo = ^bus.in_inst[RS2_LSB-1:0];

    alu_regfile u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wb_valid),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_data),
        .raddr1 (d_rs1),
        .rdata1 (rd_a),
        .raddr2 (d_rs2),
        .rdata2 (rd_b)
    );

    always_comb begin
        wb_clr = '0;
        if (bus.wb_valid && bus.wb_rd != '0) begin
            wb_clr[bus.wb_rd] = 1'b1;
        end
    end

    // A register being written back this cycle is already resolved for the
    // hazard check; the read port bypass supplies its new value.
    assign eff_pending = pending & ~wb_clr;
    assign hazard      = eff_pending[d_rs1] | eff_pending[d_rs2] | eff_pending[d_rd];
    assign issue       = d_valid && op_legal(d_op) && !hazard;
    assign drop        = d_valid && !op_legal(d_op);
    assign bus.in_ready = !d_valid || issue;
    assign accept      = bus.in_valid && bus.in_ready;

    always_comb begin
        set_mask = '0;
        if (issue && d_rd != '0) begin
            set_mask[d_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_op    <= '0;
            d_rd    <= '0;
            d_rs1   <= '0;
            d_rs2   <= '0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_op    <= bus.in_inst[OP_LSB +: 3];
            d_rd    <= bus.in_inst[RD_LSB +: RW];
            d_rs1   <= bus.in_inst[RS1_LSB +: RW];
            d_rs2   <= bus.in_inst[RS2_LSB +: RW];
        end else if (issue || drop) begin
            d_valid <= 1'b0;
        end
    end

    // Issue set is OR-ed after the writeback clear so the set wins on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= eff_pending | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.OpCode     <= '0;
            bus.x1         <= '0;
            bus.x2         <= '0;
            bus.out_rd     <= '0;
            bus.out_valid  <= 1'b0;
            bus.illegal_op <= 1'b0;
        end else begin
            bus.out_valid  <= issue;
            bus.illegal_op <= drop;
            if (issue) begin
                bus.OpCode <= d_op;
                bus.x1     <= rd_a;
                bus.x2     <= rd_b;
                bus.out_rd <= d_rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb/tb_alu_operand_fetch.sv - self-checking bench for alu_operand_fetch
module tb_alu_operand_fetch;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [2:0]  op;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [4:0]  rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    alu_operand_fetch_if ifc ();

    alu_operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        ifc.wb_valid = 1'b1;
        ifc.wb_rd    = rd;
        ifc.wb_data  = data;
        @(negedge clk);
        ifc.wb_valid = 1'b0;
    endtask

    // Returns just after the acceptance edge.
    task automatic send(input string nm, input logic [31:0] inst);
        int waited;
        waited = 0;
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_inst  = inst;
        while (!ifc.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.in_ready) chk({nm, "_accept_timeout"}, 32'(ifc.in_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic expect_issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        chk({nm, "_lat0"}, 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(ifc.out_valid), 32'd1);
        chk({nm, "_op"}, 32'(ifc.OpCode), 32'(op));
        chk({nm, "_x1"}, ifc.x1, a);
        chk({nm, "_x2"}, ifc.x2, b);
        chk({nm, "_rd"}, 32'(ifc.out_rd), 32'(rd));
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(ifc.out_valid), 32'd0);
        chk({nm, "_hold"}, ifc.x1, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        ifc.in_valid = 1'b0;
        ifc.in_inst  = '0;
        ifc.wb_valid = 1'b0;
        ifc.wb_rd    = '0;
        ifc.wb_data  = '0;

        // Reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_x1", ifc.x1, 32'd0);
        chk("rst_x2", ifc.x2, 32'd0);
        chk("rst_opcode", 32'(ifc.OpCode), 32'd0);
        chk("rst_illegal", 32'(ifc.illegal_op), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // Preload and add
        wb(5'd1, 32'h4048F5C3);
        wb(5'd2, 32'hC048F5C3);
        wb(5'd7, 32'h3F800000);
        wb(5'd8, 32'h12345678);
        wb(5'd9, 32'hFFFFFFFF);
        send("add", 32'h03088000);
        expect_issue("add", 3'b000, 32'h4048F5C3, 32'hC048F5C3, 5'd3);

        // RAW stall on r3, released by a bypassed writeback
        send("mul", 32'h64184000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("raw_stall_valid", 32'(ifc.out_valid), 32'd0);
            chk("raw_stall_ready", 32'(ifc.in_ready), 32'd0);
        end
        ifc.wb_valid = 1'b1;
        ifc.wb_rd    = 5'd3;
        ifc.wb_data  = 32'h00000000;
        @(negedge clk);
        ifc.wb_valid = 1'b0;
        chk("raw_valid", 32'(ifc.out_valid), 32'd1);
        chk("raw_op", 32'(ifc.OpCode), 32'd3);
        chk("raw_x1", ifc.x1, 32'h00000000);
        chk("raw_x2", ifc.x2, 32'h4048F5C3);
        chk("raw_rd", 32'(ifc.out_rd), 32'd4);
        wb(5'd4, 32'h0);

        // Illegal opcode is dropped without reserving r5
        send("ill", 32'hE5000000);
        @(negedge clk);
        chk("ill_ready_low", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        chk("ill_pulse", 32'(ifc.illegal_op), 32'd1);
        chk("ill_no_issue", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        chk("ill_pulse_end", 32'(ifc.illegal_op), 32'd0);
        send("r5_free", mk(3'b100, 5'd14, 5'd5, 5'd0));
        expect_issue("r5_free", 3'b100, 32'h0, 32'h0, 5'd14);
        wb(5'd14, 32'h0);

        // r0 ignores writes
        wb(5'd0, 32'h7F800000);

        vecs[0] = '{"or_r0",  32'hA6000000,           3'b101, 32'h00000000, 32'h00000000, 5'd6};
        vecs[1] = '{"sub",    mk(3'b001, 5'd10, 5'd7, 5'd8), 3'b001, 32'h3F800000, 32'h12345678, 5'd10};
        vecs[2] = '{"and",    mk(3'b100, 5'd11, 5'd9, 5'd0), 3'b100, 32'hFFFFFFFF, 32'h00000000, 5'd11};
        vecs[3] = '{"xor",    mk(3'b110, 5'd12, 5'd2, 5'd2), 3'b110, 32'hC048F5C3, 32'hC048F5C3, 5'd12};
        vecs[4] = '{"mul_r31", mk(3'b011, 5'd13, 5'd8, 5'd31), 3'b011, 32'h12345678, 32'h00000000, 5'd13};
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].name, vecs[v].inst);
            expect_issue(vecs[v].name, vecs[v].op, vecs[v].x1, vecs[v].x2, vecs[v].rd);
            wb(vecs[v].rd, 32'h0);
        end

        // Reset while an instruction is stalled
        send("pre", mk(3'b000, 5'd15, 5'd1, 5'd2));
        expect_issue("pre", 3'b000, 32'h4048F5C3, 32'hC048F5C3, 5'd15);
        send("stall", mk(3'b011, 5'd4, 5'd15, 5'd1));
        @(negedge clk);
        chk("mid_stall_ready", 32'(ifc.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ifc.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.out_valid) seen = 1'b1;
        end
        chk("lost_inst_never_issues", 32'(seen), 32'd0);
        send("post_rst", mk(3'b011, 5'd4, 5'd15, 5'd1));
        expect_issue("post_rst", 3'b011, 32'h0, 32'h0, 5'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
